// File: rtl/noc_packetizer.sv
// Purpose : NoC injection stage. Frames a payload stream into head/body/tail flits,
//           carries dest in every flit, picks a VC per packet round-robin, and tracks
//           per-VC downstream credits so no flit leaves without buffer space.
// Latency : 1 cycle, accepted beat -> registered o_flit. Idle cycles drive o_flit = 0.
// Backpres: i_ready = credit available (IDLE: any VC, BODY: the locked VC); never depends
//           on i_valid.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   i_valid/i_ready         payload handshake
//   i_data [PW-1:0]         payload, lands in flit [PW-1:0]
//   i_dest [AW-1:0]         destination node, sampled on the head beat only
//   i_last                  last beat of the packet
//   i_credit [NUM_VC-1:0]   one credit returned per set bit
//   o_flit [WIDTH-1:0]      {valid, head, tail, vc, dest, payload}
//   o_credit_err            sticky, credit returned to a VC already full
// Optional (macro NOC_PACKETIZER_STATS_EN):
//   o_pkt_count [31:0]      tail flits sent, wraps
//   o_flit_count [31:0]     flits sent, wraps

module noc_packetizer #(
  parameter int WIDTH    = 128,
  parameter int N        = 16,
  parameter int NUM_VC   = 2,
  parameter int VC_DEPTH = 16,
  localparam int AW      = $clog2(N),
  localparam int VCW     = $clog2(NUM_VC),
  localparam int PW      = WIDTH - 3 - VCW - AW,
  localparam int CW      = $clog2(VC_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [PW-1:0]     i_data,
  input  logic [AW-1:0]     i_dest,
  input  logic              i_last,
  input  logic [NUM_VC-1:0] i_credit,
  output logic [WIDTH-1:0]  o_flit,
  output logic              o_credit_err
`ifdef NOC_PACKETIZER_STATS_EN
  ,
  output logic [31:0]       o_pkt_count,
  output logic [31:0]       o_flit_count
`endif
);

  typedef enum logic {S_IDLE, S_BODY} state_e;

  state_e             state_q, state_d;
  logic [VCW-1:0]     vc_q, vc_d;        // VC locked for the packet in flight
  logic [AW-1:0]      dest_q, dest_d;    // dest latched from the head beat
  logic [VCW-1:0]     rr_q, rr_d;        // last VC used for a head flit
  logic [CW-1:0]      cnt_q [NUM_VC];
  logic [CW-1:0]      cnt_d [NUM_VC];
  logic               err_q, err_d;
  logic [WIDTH-1:0]   flit_q, flit_d;

  logic [NUM_VC-1:0]  has_cred;
  logic [VCW-1:0]     pick_vc;
  logic [VCW-1:0]     send_vc;
  logic [AW-1:0]      send_dest;
  logic               is_head;
  logic               accept;

  // Rotating index: (base + off) mod NUM_VC, valid for non power-of-two VC counts.
  function automatic logic [VCW-1:0] rr_idx(input logic [VCW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_VC;
    return VCW'(s);
  endfunction

  always_comb begin
    has_cred = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      has_cred[v] = (cnt_q[v] != '0);
    end
  end

  // Round-robin pick starting after the last used VC. Scanning from the farthest
  // candidate back to the nearest lets the nearest eligible VC win.
  always_comb begin
    pick_vc = rr_q;
    for (int off = NUM_VC; off >= 1; off--) begin
      if (has_cred[rr_idx(rr_q, off)]) begin
        pick_vc = rr_idx(rr_q, off);
      end
    end
  end

  assign i_ready   = (state_q == S_IDLE) ? (|has_cred) : has_cred[vc_q];
  assign accept    = i_valid & i_ready;
  assign is_head   = (state_q == S_IDLE);
  assign send_vc   = is_head ? pick_vc : vc_q;
  assign send_dest = is_head ? i_dest  : dest_q;

  // Framing FSM and per-packet locks.
  always_comb begin
    state_d = state_q;
    vc_d    = vc_q;
    dest_d  = dest_q;
    rr_d    = rr_q;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          rr_d   = pick_vc;
          vc_d   = pick_vc;
          dest_d = i_dest;
          if (!i_last) begin
            state_d = S_BODY;
          end
        end
        S_BODY: begin
          if (i_last) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Flit assembly; a cycle without an accepted beat emits an all-zero flit.
  always_comb begin
    flit_d = '0;
    if (accept) begin
      flit_d[WIDTH-1]             = 1'b1;
      flit_d[WIDTH-2]             = is_head;
      flit_d[WIDTH-3]             = i_last;
      flit_d[WIDTH-4 -: VCW]      = send_vc;
      flit_d[WIDTH-4-VCW -: AW]   = send_dest;
      flit_d[PW-1:0]              = i_data;
    end
  end

  // Credit accounting. A send and a return on the same VC cancel out; a lone return
  // to a full VC is a protocol error: the count saturates and the error latches.
  always_comb begin
    err_d = err_q;
    for (int v = 0; v < NUM_VC; v++) begin
      cnt_d[v] = cnt_q[v];
      if (accept && (send_vc == VCW'(v)) && !i_credit[v]) begin
        cnt_d[v] = cnt_q[v] - CW'(1);
      end else if (i_credit[v] && !(accept && (send_vc == VCW'(v)))) begin
        if (cnt_q[v] == CW'(VC_DEPTH)) begin
          err_d = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vc_q    <= '0;
      dest_q  <= '0;
      rr_q    <= VCW'(NUM_VC - 1);   // first head after reset lands on VC0
      err_q   <= 1'b0;
      flit_q  <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        cnt_q[v] <= CW'(VC_DEPTH);
      end
    end else begin
      state_q <= state_d;
      vc_q    <= vc_d;
      dest_q  <= dest_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      flit_q  <= flit_d;
      for (int v = 0; v < NUM_VC; v++) begin
        cnt_q[v] <= cnt_d[v];
      end
    end
  end

  assign o_flit       = flit_q;
  assign o_credit_err = err_q;

`ifdef NOC_PACKETIZER_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] flit_cnt_q;

  // Counted at accept so the totals move on the same edge the flit appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      flit_cnt_q <= '0;
    end else if (accept) begin
      flit_cnt_q <= flit_cnt_q + 32'd1;
      if (i_last) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
    end
  end

  assign o_pkt_count  = pkt_cnt_q;
  assign o_flit_count = flit_cnt_q;
`endif

endmodule
